// File: rtl/control_transfer_predictor_pkg.sv
// Shared constants for the control-transfer predictor:
//   - RV64I branch funct3 encodings
//   - pc_sel encodings (same as the single-cycle unit)
//   - 2-bit saturating counter states and increment/decrement helpers
package control_transfer_predictor_pkg;

  localparam logic [2:0] BRANCH_BEQ  = 3'b000;
  localparam logic [2:0] BRANCH_BNE  = 3'b001;
  localparam logic [2:0] BRANCH_BLT  = 3'b100;
  localparam logic [2:0] BRANCH_BGE  = 3'b101;
  localparam logic [2:0] BRANCH_BLTU = 3'b110;
  localparam logic [2:0] BRANCH_BGEU = 3'b111;

  localparam logic [1:0] PC_SEL_PC4  = 2'b00;
  localparam logic [1:0] PC_SEL_IMM  = 2'b01;
  localparam logic [1:0] PC_SEL_JALR = 2'b10;

  localparam logic [1:0] CNT_STRONG_NT = 2'b00;
  localparam logic [1:0] CNT_WEAK_NT   = 2'b01;
  localparam logic [1:0] CNT_WEAK_T    = 2'b10;
  localparam logic [1:0] CNT_STRONG_T  = 2'b11;

  function automatic logic [1:0] cnt_inc(input logic [1:0] c);
    return (c == CNT_STRONG_T) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] cnt_dec(input logic [1:0] c);
    return (c == CNT_STRONG_NT) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/control_transfer_predictor_table.sv
// Direct-mapped BHT+BTB storage.
//   clk_i/rst_ni       : clock, async active-low clear (valid=0, counter=01)
//   lkp_pc_i           : fetch PC; lkp_taken_o/lkp_target_o combinational
//   upd_en_i           : commit one resolved transfer on the next rising edge
//   upd_pc_i           : PC of the resolved instruction
//   upd_taken_i        : resolved direction
//   upd_strong_i       : allocate at strongly-taken (unconditional jumps)
//   upd_target_i       : resolved target, written only when taken
// Lookup reads the registered contents, so a same-cycle update of the
// same index is not visible until the following cycle.
module btb_bht_table
  import control_transfer_predictor_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 12
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] lkp_pc_i,
  output logic            lkp_taken_o,
  output logic [XLEN-1:0] lkp_target_o,
  input  logic            upd_en_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic            upd_strong_i,
  input  logic [XLEN-1:0] upd_target_i
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_LO  = INDEX_BITS + 2;
  localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

  logic [ENTRIES-1:0]                valid_q;
  logic [ENTRIES-1:0][TAG_BITS-1:0]  tag_q;
  logic [ENTRIES-1:0][XLEN-1:0]      tgt_q;
  logic [ENTRIES-1:0][1:0]           cnt_q;

  logic [INDEX_BITS-1:0] lkp_idx, upd_idx;
  logic [TAG_BITS-1:0]   lkp_tag, upd_tag;
  logic                  upd_hit;
  logic                  wr_en_d;
  logic [1:0]            cnt_d;

  assign lkp_idx = lkp_pc_i[INDEX_BITS+1:2];
  assign lkp_tag = lkp_pc_i[TAG_HI:TAG_LO];
  assign upd_idx = upd_pc_i[INDEX_BITS+1:2];
  assign upd_tag = upd_pc_i[TAG_HI:TAG_LO];

  assign lkp_taken_o  = valid_q[lkp_idx] & (tag_q[lkp_idx] == lkp_tag) & cnt_q[lkp_idx][1];
  assign lkp_target_o = tgt_q[lkp_idx];

  assign upd_hit = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);

  // Taken: train up on a hit, otherwise (re)allocate. Not-taken only
  // trains an entry that already belongs to this PC.
  always_comb begin
    wr_en_d = 1'b0;
    cnt_d   = cnt_q[upd_idx];
    if (upd_en_i) begin
      if (upd_taken_i) begin
        wr_en_d = 1'b1;
        cnt_d   = upd_hit ? cnt_inc(cnt_q[upd_idx])
                          : (upd_strong_i ? CNT_STRONG_T : CNT_WEAK_T);
      end else if (upd_hit) begin
        wr_en_d = 1'b1;
        cnt_d   = cnt_dec(cnt_q[upd_idx]);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      tag_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= {ENTRIES{CNT_WEAK_NT}};
    end else if (wr_en_d) begin
      cnt_q[upd_idx] <= cnt_d;
      if (upd_taken_i) begin
        valid_q[upd_idx] <= 1'b1;
        tag_q[upd_idx]   <= upd_tag;
        tgt_q[upd_idx]   <= upd_target_i;
      end
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lkp_pc_i[XLEN-1:TAG_HI+1], lkp_pc_i[1:0],
                            upd_pc_i[XLEN-1:TAG_HI+1], upd_pc_i[1:0]};

endmodule

// File: rtl/control_transfer_predictor.sv
// EX-stage control-transfer resolver with fetch-side predictor.
//   clock/reset          : core clock, async active-low reset
//   fetch_pc -> pred_*   : combinational BTB/BHT lookup for IF
//   ex_* / *_en          : instruction being resolved in EX plus the
//                          prediction that travelled with it
//   pc_sel               : 00 PC+4, 01 PC+imm, 10 JALR
//   flush / redirect_pc  : same-cycle mispredict recovery
//   resolve_count / mispredict_count : saturating performance counters
module control_transfer_predictor
  import control_transfer_predictor_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 12,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [XLEN-1:0]      fetch_pc,
  output logic                 pred_taken,
  output logic [XLEN-1:0]      pred_target,
  input  logic                 ex_valid,
  input  logic                 ex_stall,
  input  logic                 branch_en,
  input  logic                 jal_en,
  input  logic                 jalr_en,
  input  logic                 result_eq_zero,
  input  logic [2:0]           inst_funct3,
  input  logic [XLEN-1:0]      ex_pc,
  input  logic [XLEN-1:0]      ex_imm_target,
  input  logic [XLEN-1:0]      ex_jalr_target,
  input  logic                 ex_pred_taken,
  input  logic [XLEN-1:0]      ex_pred_target,
  output logic [1:0]           pc_sel,
  output logic                 flush,
  output logic [XLEN-1:0]      redirect_pc,
  output logic [CNT_WIDTH-1:0] resolve_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  logic                 live_q;       // low until the first edge after reset release
  logic                 resolve;
  logic                 actual_taken;
  logic [XLEN-1:0]      actual_target;
  logic                 upd_ok;
  logic                 mispredict;
  logic                 commit;
  logic [CNT_WIDTH-1:0] resolve_cnt_q, resolve_cnt_d;
  logic [CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;

  // The edge that releases reset only arms live_q; nothing else commits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) live_q <= 1'b0;
    else        live_q <= 1'b1;
  end

  // Gating on reset keeps flush/pc_sel/redirect_pc at zero while it is held.
  assign resolve = reset & ex_valid & ~ex_stall & (branch_en | jal_en | jalr_en);

  // Branch wins over JAL, JAL over JALR.
  always_comb begin
    actual_taken  = 1'b0;
    actual_target = ex_imm_target;
    upd_ok        = 1'b1;
    pc_sel        = PC_SEL_PC4;
    if (branch_en) begin
      case (inst_funct3)
        BRANCH_BEQ, BRANCH_BGE, BRANCH_BGEU: actual_taken = result_eq_zero;
        BRANCH_BNE, BRANCH_BLT, BRANCH_BLTU: actual_taken = ~result_eq_zero;
        default:                             upd_ok       = 1'b0;
      endcase
      pc_sel = actual_taken ? PC_SEL_IMM : PC_SEL_PC4;
    end else if (jal_en) begin
      actual_taken = 1'b1;
      pc_sel       = PC_SEL_IMM;
    end else if (jalr_en) begin
      actual_taken  = 1'b1;
      actual_target = {ex_jalr_target[XLEN-1:1], 1'b0};
      pc_sel        = PC_SEL_JALR;
    end
    if (!resolve) pc_sel = PC_SEL_PC4;
  end

  assign mispredict = resolve &
                      ((actual_taken != ex_pred_taken) |
                       (actual_taken & ex_pred_taken & (actual_target != ex_pred_target)));

  assign flush       = mispredict;
  assign redirect_pc = !mispredict  ? '0 :
                       actual_taken ? actual_target : ex_pc + XLEN'(4);

  assign commit = resolve & live_q;

  btb_bht_table #(
    .XLEN       (XLEN),
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_table (
    .clk_i        (clock),
    .rst_ni       (reset),
    .lkp_pc_i     (fetch_pc),
    .lkp_taken_o  (pred_taken),
    .lkp_target_o (pred_target),
    .upd_en_i     (commit & upd_ok),
    .upd_pc_i     (ex_pc),
    .upd_taken_i  (actual_taken),
    .upd_strong_i (~branch_en),
    .upd_target_i (actual_target)
  );

  always_comb begin
    resolve_cnt_d = resolve_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (commit && !(&resolve_cnt_q))               resolve_cnt_d = resolve_cnt_q + 1'b1;
    if (commit && mispredict && !(&mispred_cnt_q)) mispred_cnt_d = mispred_cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resolve_cnt_q <= '0;
      mispred_cnt_q <= '0;
    end else begin
      resolve_cnt_q <= resolve_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign resolve_count    = resolve_cnt_q;
  assign mispredict_count = mispred_cnt_q;

endmodule

// File: tb/tb_control_transfer_predictor.sv
module tb_control_transfer_predictor;
  localparam int XLEN = 64;
  localparam int IB   = 6;
  localparam int TB   = 12;
  localparam int CW   = 4;
  localparam int NENT = 64;
  localparam int CMAX = 15;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [XLEN-1:0] fetch_pc = '0;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            ex_valid = 0, ex_stall = 0, branch_en = 0, jal_en = 0, jalr_en = 0;
  logic            result_eq_zero = 0;
  logic [2:0]      inst_funct3 = '0;
  logic [XLEN-1:0] ex_pc = '0, ex_imm_target = '0, ex_jalr_target = '0, ex_pred_target = '0;
  logic            ex_pred_taken = 0;
  logic [1:0]      pc_sel;
  logic            flush;
  logic [XLEN-1:0] redirect_pc;
  logic [CW-1:0]   resolve_count, mispredict_count;

  always #5 clock = ~clock;

  control_transfer_predictor #(.XLEN(XLEN), .INDEX_BITS(IB), .TAG_BITS(TB), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .branch_en(branch_en), .jal_en(jal_en), .jalr_en(jalr_en),
    .result_eq_zero(result_eq_zero), .inst_funct3(inst_funct3), .ex_pc(ex_pc),
    .ex_imm_target(ex_imm_target), .ex_jalr_target(ex_jalr_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .pc_sel(pc_sel), .flush(flush), .redirect_pc(redirect_pc),
    .resolve_count(resolve_count), .mispredict_count(mispredict_count));

  typedef struct {
    logic            pt;
    logic [XLEN-1:0] ptg;
    logic            fl;
    logic [XLEN-1:0] rd;
    logic [1:0]      ps;
    int              rc;
    int              mc;
  } exp_t;

  exp_t q[$];
  int tests = 0, fails = 0;

  // Reference predictor: one record per table slot, counters as integers.
  bit              mv  [NENT];
  int              mtag[NENT];
  logic [XLEN-1:0] mtgt[NENT];
  int              mcnt[NENT];
  int              m_rc, m_mc;

  function automatic int m_idx(logic [XLEN-1:0] pc); return int'((pc >> 2) % 64);   endfunction
  function automatic int m_tag(logic [XLEN-1:0] pc); return int'((pc >> 8) % 4096); endfunction
  function automatic bit m_hit(logic [XLEN-1:0] pc);
    return mv[m_idx(pc)] && mtag[m_idx(pc)] == m_tag(pc);
  endfunction
  function automatic bit m_pred(logic [XLEN-1:0] pc);
    return m_hit(pc) && mcnt[m_idx(pc)] >= 2;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NENT; i++) begin mv[i] = 0; mtag[i] = 0; mtgt[i] = '0; mcnt[i] = 1; end
    m_rc = 0; m_mc = 0;
  endtask

  task automatic chk(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every cycle that has a queued expectation is compared here.
  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pred_taken",  XLEN'(pred_taken),       XLEN'(e.pt));
      chk("pred_target", pred_target,             e.ptg);
      chk("flush",       XLEN'(flush),            XLEN'(e.fl));
      chk("redirect_pc", redirect_pc,             e.rd);
      chk("pc_sel",      XLEN'(pc_sel),           XLEN'(e.ps));
      chk("resolve_cnt", XLEN'(resolve_count),    XLEN'(e.rc));
      chk("mispred_cnt", XLEN'(mispredict_count), XLEN'(e.mc));
    end
  end

  // One cycle of stimulus: drive, predict the visible outputs, advance the model.
  task automatic cyc(input logic [XLEN-1:0] fpc, input bit v, st, b, j, jr, eq,
                     input logic [2:0] f3, input logic [XLEN-1:0] pc, imm, jt,
                     input bit ptk, input logic [XLEN-1:0] ptg);
    exp_t e;
    bit res, tk, mis, upd;
    logic [XLEN-1:0] tgt;
    int i;
    @(posedge clock); #1;
    fetch_pc = fpc; ex_valid = v; ex_stall = st; branch_en = b; jal_en = j; jalr_en = jr;
    result_eq_zero = eq; inst_funct3 = f3; ex_pc = pc; ex_imm_target = imm;
    ex_jalr_target = jt; ex_pred_taken = ptk; ex_pred_target = ptg;

    e.pt = m_pred(fpc);
    e.ptg = mtgt[m_idx(fpc)];
    res = v && !st && (b || j || jr);
    upd = 1; tk = 0; tgt = imm;
    if (b) begin
      if (f3 inside {3'd0, 3'd5, 3'd7})      tk = eq;
      else if (f3 inside {3'd1, 3'd4, 3'd6}) tk = !eq;
      else                                   upd = 0;
    end else if (j) tk = 1;
    else if (jr) begin tk = 1; tgt = jt & ~64'd1; end
    mis  = res && (tk != ptk || (tk && ptk && tgt != ptg));
    e.fl = mis;
    e.rd = !mis ? '0 : (tk ? tgt : pc + 64'd4);
    e.ps = !res ? 2'd0 : (b ? (tk ? 2'd1 : 2'd0) : (j ? 2'd1 : 2'd2));
    e.rc = m_rc; e.mc = m_mc;
    q.push_back(e);

    if (res) begin
      if (m_rc < CMAX) m_rc++;
      if (mis && m_mc < CMAX) m_mc++;
      if (upd) begin
        i = m_idx(pc);
        if (tk) begin
          if (m_hit(pc)) mcnt[i] = (mcnt[i] < 3) ? mcnt[i] + 1 : 3;
          else           mcnt[i] = b ? 2 : 3;
          mv[i] = 1; mtag[i] = m_tag(pc); mtgt[i] = tgt;
        end else if (m_hit(pc)) begin
          mcnt[i] = (mcnt[i] > 0) ? mcnt[i] - 1 : 0;
        end
      end
    end
  endtask

  task automatic idle(input logic [XLEN-1:0] fpc);
    cyc(fpc, 0, 0, 0, 0, 0, 0, 3'd0, '0, '0, '0, 0, '0);
  endtask

  logic [XLEN-1:0] pcs [8];
  logic [XLEN-1:0] tgs [4];

  task automatic rand_cycles(input int n);
    logic [XLEN-1:0] pc, tg, ptg;
    bit b, j, jr, ptk;
    int k;
    for (int c = 0; c < n; c++) begin
      pc = pcs[$urandom_range(0, 7)];
      tg = tgs[$urandom_range(0, 3)];
      k  = $urandom_range(0, 9);
      b = (k < 6); j = (k == 6 || k == 7); jr = (k >= 8);
      if ($urandom_range(0, 7) == 0) begin j = 1; jr = 1; end
      if ($urandom_range(0, 9) < 6) begin ptk = m_pred(pc); ptg = mtgt[m_idx(pc)]; end
      else begin ptk = 1'($urandom); ptg = tgs[$urandom_range(0, 3)]; end
      cyc(pcs[$urandom_range(0, 7)], $urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0,
          b, j, jr, 1'($urandom), 3'($urandom), pc, tg, tg | 64'($urandom_range(0, 1)), ptk, ptg);
    end
  endtask

  initial begin
    pcs = '{64'h100, 64'h200, 64'h200 + 64'h100, 64'h3fc, 64'h0010_0100,
            64'h40, 64'h8000_0000_0000_0040, 64'hffff_ffff_ffff_fffc};
    tgs = '{64'h180, 64'h2000, 64'h3000, 64'h100};
    m_reset();
    repeat (3) @(posedge clock);
    #3 reset = 1'b1;
    idle('0); idle('0);

    // Cold miss, then mispredicted taken BEQ allocates weakly-taken.
    idle(64'h100);
    cyc(64'h100, 1, 0, 1, 0, 0, 1, 3'd0, 64'h100, 64'h180, '0, 0, '0);
    idle(64'h100);
    repeat (3) cyc(64'h100, 1, 0, 1, 0, 0, 1, 3'd0, 64'h100, 64'h180, '0, 1, 64'h180);
    // Two not-taken resolutions walk the counter 11 -> 10 -> 01.
    cyc(64'h100, 1, 0, 1, 0, 0, 0, 3'd0, 64'h100, 64'h180, '0, 1, 64'h180);
    idle(64'h100);
    cyc(64'h100, 1, 0, 1, 0, 0, 0, 3'd0, 64'h100, 64'h180, '0, 1, 64'h180);
    idle(64'h100);
    // JALR target masking: correct and wrong carried prediction.
    cyc(64'h400, 1, 0, 0, 0, 1, 0, 3'd0, 64'h400, '0, 64'h2001, 1, 64'h2000);
    cyc(64'h400, 1, 0, 0, 0, 1, 0, 3'd0, 64'h400, '0, 64'h2001, 1, 64'h3000);
    idle(64'h400);
    // Aliasing: same index, different tag replaces the entry.
    cyc(64'h100, 1, 0, 1, 0, 0, 1, 3'd0, 64'h100, 64'h180, '0, 0, '0);
    cyc(64'h100, 1, 0, 1, 0, 0, 1, 3'd0, 64'h200, 64'h280, '0, 0, '0);
    idle(64'h100); idle(64'h200);
    // Stalled mispredicting BNE has no effect.
    cyc(64'h300, 1, 1, 1, 0, 0, 0, 3'd1, 64'h300, 64'h380, '0, 0, '0);
    idle(64'h300);
    // funct3 010 resolves (and may mispredict) but never trains.
    cyc(64'h300, 1, 0, 1, 0, 0, 1, 3'd2, 64'h300, 64'h380, '0, 1, 64'h380);
    idle(64'h300);
    // Counter saturation at 4'hF.
    repeat (20) cyc(64'h500, 1, 0, 0, 1, 0, 0, 3'd0, 64'h500, 64'h900, '0, 0, '0);
    idle(64'h500);

    rand_cycles(400);

    // Asynchronous reset in the middle of a mispredicting resolve.
    @(posedge clock); #1;
    fetch_pc = 64'h500; ex_valid = 1; ex_stall = 0; branch_en = 0; jal_en = 1; jalr_en = 0;
    ex_pc = 64'h500; ex_imm_target = 64'h900; ex_pred_taken = 0;
    #2 reset = 1'b0;
    #1;
    chk("rst pred_taken",  XLEN'(pred_taken),       '0);
    chk("rst pred_target", pred_target,             '0);
    chk("rst flush",       XLEN'(flush),            '0);
    chk("rst pc_sel",      XLEN'(pc_sel),           '0);
    chk("rst redirect_pc", redirect_pc,             '0);
    chk("rst resolve_cnt", XLEN'(resolve_count),    '0);
    chk("rst mispred_cnt", XLEN'(mispredict_count), '0);
    m_reset();
    @(posedge clock); #1;
    ex_valid = 0; jal_en = 0;
    @(posedge clock); #3 reset = 1'b1;
    idle('0); idle(64'h500);

    rand_cycles(100);
    idle('0);
    @(posedge clock); #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/control_transfer_predictor.md
Name: control_transfer_predictor

Overview:
Pipelined successor to the single-cycle control-transfer unit. It resolves branch, JAL and JALR outcomes in the execute stage and checks them against the fetch-stage prediction. It raises a flush/redirect on mispredict and trains a parametrised direct-mapped BHT+BTB that supplies predictions to fetch. It sits between the IF and EX stages of the pipelined RV64I core and also keeps resolve/mispredict performance counters.

Parameters:
XLEN, 64, address/data width
INDEX_BITS, 6, log2 of table entries (2**INDEX_BITS entries)
TAG_BITS, 12, PC tag bits stored per BTB entry
CNT_WIDTH, 32, width of each performance counter

Ports:
clock  in  1  core clock, rising edge
reset  in  1  asynchronous reset, active-low
fetch_pc  in  XLEN  PC currently being fetched
pred_taken  out  1  fetch prediction: redirect to pred_target
pred_target  out  XLEN  predicted target
ex_valid  in  1  EX stage holds a valid instruction
ex_stall  in  1  EX held this cycle; no resolve, no update
branch_en  in  1  EX instruction is a branch
jal_en  in  1  EX instruction is JAL
jalr_en  in  1  EX instruction is JALR
result_eq_zero  in  1  ALU result == 0
inst_funct3  in  3  funct3 of EX instruction
ex_pc  in  XLEN  PC of EX instruction
ex_imm_target  in  XLEN  ex_pc + imm
ex_jalr_target  in  XLEN  rs1 + imm (unmasked)
ex_pred_taken  in  1  prediction carried down the pipe with the instruction
ex_pred_target  in  XLEN  predicted target carried down the pipe
pc_sel  out  2  00 PC+4, 01 PC+imm, 10 JALR (same encoding as single-cycle)
flush  out  1  mispredict: kill IF/ID and redirect
redirect_pc  out  XLEN  correct next PC when flush=1
resolve_count  out  CNT_WIDTH  resolved control transfers
mispredict_count  out  CNT_WIDTH  mispredicts

Behaviour:
- Index = PC[INDEX_BITS+1:2]. Tag = PC[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2].
- Each entry holds: valid, tag, XLEN target, 2-bit saturating counter.
- Lookup is combinational from fetch_pc. pred_taken = valid & tag match & counter[1]. pred_target = stored target.
- Resolve is active when ex_valid & ~ex_stall & (branch_en|jal_en|jalr_en). Priority is branch > jal > jalr.
- Branch outcome:
  - BEQ/BGE/BGEU: taken when result_eq_zero.
  - BNE/BLT/BLTU: taken when ~result_eq_zero.
  - funct3 010/011: not taken and no table update; resolution is still checked.
- Actual target:
  - branch and JAL: ex_imm_target.
  - JALR: {ex_jalr_target[XLEN-1:1], 1'b0}.
- pc_sel (combinational): 01 for a taken branch or JAL, 10 for JALR, otherwise 00. pc_sel is also 00 whenever resolve is inactive.
- Mispredict, when resolve is active, if either holds:
  - actual_taken != ex_pred_taken.
  - actual_taken & ex_pred_taken & target != ex_pred_target.
- Mispredict handling:
  - flush = mispredict, combinational, same cycle.
  - redirect_pc = actual target if taken, else ex_pc+4 (mod 2**XLEN).
  - When flush=0, redirect_pc is 0.
- Update on the rising clock edge after a resolve:
  - Taken: write valid=1, tag, target. Counter saturates up (11 stays 11). A newly allocated entry (tag miss or invalid) starts at 10; JAL/JALR allocations start at 11.
  - Not-taken branch on a tag hit: counter saturates down (00 stays 00). On a tag miss there is no write.
- Same-cycle lookup and update of the same index: lookup returns the pre-update contents (no bypass).
- Counters:
  - resolve_count +1 per resolve; mispredict_count +1 per mispredict.
  - Both saturate at all-ones.
  - Counting happens when ex_stall=0 and is gated by resolve being active.
- Reset (asynchronous, any time, including mid-resolve):
  - All valid=0, counters=01, targets/tags=0, performance counters=0.
  - Outputs: pred_taken=0, pred_target=0, flush=0, pc_sel=00, redirect_pc=0.
  - No update is committed on the edge where reset is released.

Decomposition:
- Shared package/header: BRANCH_* funct3 constants, PC_SEL_* encodings, counter constants CNT_WEAK_NT=01, CNT_WEAK_T=10, CNT_STRONG_T=11.
- Sub-module btb_bht_table (storage, lookup port, write port, async clear).
- The top level holds the resolve/mispredict logic and the counters.

Test Plan:
- Reset, then fetch_pc=0x100 -> pred_taken=0. BEQ at 0x100 with result_eq_zero=1, ex_pred_taken=0, target 0x180 -> flush=1, redirect_pc=0x180, pc_sel=01; next cycle fetch_pc=0x100 -> pred_taken=1, pred_target=0x180.
- Same BEQ resolved taken 3 more times, then not-taken once (result_eq_zero=0, ex_pred_taken=1) -> flush=1, redirect_pc=0x104, pc_sel=00; entry counter 10, still pred_taken=1; a second not-taken -> pred_taken=0.
- JALR, ex_jalr_target=0x2001, ex_pred_taken=1, ex_pred_target=0x2000 -> no flush, pc_sel=10. Same case with ex_pred_target=0x3000 -> flush=1, redirect_pc=0x2000.
- Aliasing: taken branch at 0x100 and at 0x100+4*2**INDEX_BITS with INDEX_BITS=6 -> second overwrites tag; fetch 0x100 -> pred_taken=0.
- ex_stall=1 with a mispredicting BNE -> flush=0, pc_sel=00, no table/counter change. Assert reset mid-stream -> all outputs 0, lookup misses, counters 0.
- CNT_WIDTH=4: 20 resolves, 20 mispredicts -> both counters hold 4'hF.
